// File: rtl/bin_to_bcd_display_if.sv
// Handshake and result bundle between a binary source and the BCD converter.
// The master drives the operand; the slave returns the BCD result and status.
interface bin_to_bcd_display_if #(
  parameter int unsigned IN_WIDTH = 27
);
  logic [IN_WIDTH-1:0] data_in;
  logic                valid_in;
  logic                ready_out;
  logic [31:0]         val_out;
  logic                done_out;
  logic                ovf_out;

  modport master (
    output data_in, valid_in,
    input  ready_out, val_out, done_out, ovf_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, val_out, done_out, ovf_out
  );
endinterface

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble converter: one operand bit per clock, saturating at all-9s.
// The displayed result only changes on the final shift, so the display never flickers.
module bin_to_bcd_display #(
  parameter int unsigned IN_WIDTH = 27,
  parameter int unsigned DIGITS   = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  bin_to_bcd_display_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);

  function automatic longint unsigned max_decimal(int unsigned d);
    longint unsigned m;
    m = 1;
    for (int unsigned i = 0; i < d; i++) m = m * 10;
    return m - 1;
  endfunction

  localparam logic [IN_WIDTH-1:0] MAX_VAL   = IN_WIDTH'(max_decimal(DIGITS));
  localparam logic [CNT_W-1:0]    LAST_STEP = CNT_W'(IN_WIDTH - 1);

  typedef enum logic {IDLE, CONVERT} state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] opnd_q, opnd_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         val_q, val_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic                pend_q, pend_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_shift;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    // Add-3 per nibble in parallel; no carry crosses a digit boundary.
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], opnd_q[IN_WIDTH-1]};

    state_d = state_q;
    opnd_d  = opnd_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    pend_d  = pend_q;

    unique case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          pend_d  = bus.data_in > MAX_VAL;
          opnd_d  = pend_d ? MAX_VAL : bus.data_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d  = bcd_shift;
        opnd_d = {opnd_q[IN_WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          val_d   = 32'(bcd_shift);
          ovf_d   = pend_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_out = (state_q == IDLE);
    bus.val_out   = val_q;
    bus.done_out  = done_q;
    bus.ovf_out   = ovf_q;
  end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed and randomized checks of the BCD converter at 8 and 4 digits
// against a decimal-arithmetic reference.
module tb_bin_to_bcd_display;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bin_to_bcd_display_if #(.IN_WIDTH(27)) big_if ();
  bin_to_bcd_display_if #(.IN_WIDTH(14)) small_if ();

  bin_to_bcd_display #(.IN_WIDTH(27), .DIGITS(8)) u_big (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (big_if)
  );

  bin_to_bcd_display #(.IN_WIDTH(14), .DIGITS(4)) u_small (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (small_if)
  );

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: saturate, then peel decimal digits with / and %.
  function automatic logic [32:0] ref_conv(longint unsigned v, int unsigned digits);
    longint unsigned mx;
    logic [31:0]     r;
    logic            o;
    mx = 1;
    for (int unsigned i = 0; i < digits; i++) mx = mx * 10;
    mx = mx - 1;
    o  = v > mx;
    if (o) v = mx;
    r = '0;
    for (int unsigned k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {o, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic conv_big(longint unsigned v);
    logic [32:0] e;
    logic [31:0] old_val;
    logic        old_ovf;
    logic        held;
    int          n;
    e = ref_conv(v, 8);
    n = 0;
    while (big_if.ready_out !== 1'b1 && n < 40) begin step(); n++; end
    chk("big_ready_idle", 64'(big_if.ready_out), 64'd1);
    old_val = big_if.val_out;
    old_ovf = big_if.ovf_out;
    big_if.data_in  = 27'(v);
    big_if.valid_in = 1'b1;
    step();
    big_if.valid_in = 1'b0;
    held = 1'b1;
    n = 0;
    while (big_if.done_out !== 1'b1 && n < 40) begin
      if (big_if.ready_out !== 1'b0 || big_if.val_out !== old_val || big_if.ovf_out !== old_ovf)
        held = 1'b0;
      step();
      n++;
    end
    chk("big_hold_busy", 64'(held), 64'd1);
    chk("big_latency", 64'(n), 64'd27);
    chk("big_val", 64'(big_if.val_out), 64'(e[31:0]));
    chk("big_ovf", 64'(big_if.ovf_out), 64'(e[32]));
    chk("big_ready_at_done", 64'(big_if.ready_out), 64'd1);
    step();
    chk("big_done_one_cycle", 64'(big_if.done_out), 64'd0);
  endtask

  task automatic conv_small(longint unsigned v);
    logic [32:0] e;
    int          n;
    e = ref_conv(v, 4);
    n = 0;
    while (small_if.ready_out !== 1'b1 && n < 40) begin step(); n++; end
    small_if.data_in  = 14'(v);
    small_if.valid_in = 1'b1;
    step();
    small_if.valid_in = 1'b0;
    n = 0;
    while (small_if.done_out !== 1'b1 && n < 40) begin step(); n++; end
    chk("small_latency", 64'(n), 64'd14);
    chk("small_val", 64'(small_if.val_out), 64'(e[31:0]));
    chk("small_ovf", 64'(small_if.ovf_out), 64'(e[32]));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [26:0] q[$];
    logic [32:0] e;
    logic        quiet;
    int          last;
    int          accepts;

    rst_n = 1'b0;
    big_if.valid_in   = 1'b0;
    big_if.data_in    = '0;
    small_if.valid_in = 1'b0;
    small_if.data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_val", 64'(big_if.val_out), 64'd0);
    chk("rst_ready", 64'(big_if.ready_out), 64'd1);
    chk("rst_done", 64'(big_if.done_out), 64'd0);
    chk("rst_ovf", 64'(big_if.ovf_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    conv_big(0);
    conv_big(12345678);
    conv_big(99999999);
    conv_big(100000000);
    conv_big(5);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 2) conv_big(longint'($urandom_range(134217727, 100000000)));
      else            conv_big(longint'($urandom_range(99999999, 0)));
    end

    // valid held high, data alternating every cycle; busy cycles are dropped
    last    = -1;
    accepts = 0;
    for (int cyc = 0; cyc < 141; cyc++) begin
      big_if.valid_in = (cyc < 113);
      big_if.data_in  = (cyc % 2 == 1) ? 27'd7 : 27'd42;
      if (big_if.valid_in && big_if.ready_out) begin
        if (last >= 0) chk("alt_accept_gap", 64'(cyc - last), 64'd28);
        last = cyc;
        accepts++;
        q.push_back(big_if.data_in);
      end
      step();
      if (big_if.done_out === 1'b1) begin
        chk("alt_done_has_pending", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          e = ref_conv(longint'(q.pop_front()), 8);
          chk("alt_val", 64'(big_if.val_out), 64'(e[31:0]));
        end
      end
    end
    big_if.valid_in = 1'b0;
    chk("alt_accepts", 64'(accepts), 64'd5);
    chk("alt_all_done", 64'(q.size()), 64'd0);

    // reset mid-conversion
    big_if.data_in  = 27'd87654321;
    big_if.valid_in = 1'b1;
    step();
    big_if.valid_in = 1'b0;
    repeat (9) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_val", 64'(big_if.val_out), 64'd0);
    chk("midrst_ready", 64'(big_if.ready_out), 64'd1);
    chk("midrst_done", 64'(big_if.done_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (big_if.done_out !== 1'b0) quiet = 1'b0;
    end
    chk("midrst_no_done", 64'(quiet), 64'd1);
    conv_big(321);

    conv_small(9999);
    conv_small(10000);
    conv_small(16383);
    conv_small(0);
    for (int i = 0; i < 8; i++) conv_small(longint'($urandom_range(16383, 0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
